paddle_adc_scheduler: RTL and testbench

Time-shares one external 8-bit ADC between the two paddle potentiometers (player 1, player 2) through an external analog mux. The block:
- sequences channel select, settling, conversion start and completion wait;
- averages 2^AVG_LOG2 samples per channel;
- publishes one filtered 8-bit paddle value per player with a valid strobe.

It sits between the JPorts ADC pins and the paddle position logic, and replaces direct pin sampling.

---
 rtl/pong_adc_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/paddle_adc_scheduler.sv | 169 ++++++++++++++++
 tb/tb_paddle_adc_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_adc_pkg.sv
// Shared definitions for the paddle ADC scheduler.
// Holds the scheduler state encoding, the channel numbering used on
// adc_mux_sel, and the ADC result width.
package pong_adc_pkg;

  localparam int ADC_W = 8;

  localparam logic CH_P1 = 1'b0;
  localparam logic CH_P2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    CAPTURE,
    PUBLISH,
    TIMEOUT
  } sched_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   sys_clk - destination clock
//   reset   - synchronous active-high reset, clears both flops to 0
//   d       - asynchronous input level
//   q       - synchronized level, two sys_clk cycles behind d
module sync_2ff (
  input  logic sys_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to resolve.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_adc_scheduler.sv
// Time-shares one external 8-bit ADC between the two paddle potentiometers.
// For each channel it selects the analog mux, waits for the input to settle,
// runs 2^AVG_LOG2 conversions, averages them and publishes the result with a
// one-cycle valid strobe, then moves to the other channel.
// Ports:
//   sys_clk, reset       - clock and synchronous active-high reset
//   enable               - keep scanning while high (checked at channel boundaries)
//   adc_data, adc_ready  - ADC result and asynchronous end-of-conversion level
//   adc_mux_sel          - analog mux select (0 = player 1, 1 = player 2)
//   adc_start            - start-of-conversion pulse to the ADC
//   p1_value, p2_value   - latest averaged value per player
//   p1_valid, p2_valid   - one-cycle update strobes
//   busy                 - scheduler not idle
//   timeout_err          - sticky conversion-timeout flag
module paddle_adc_scheduler
  import pong_adc_pkg::*;
#(
  parameter int SETTLE_CYCLES      = 1000,
  parameter int START_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int AVG_LOG2           = 2
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_ready,
  output logic             adc_mux_sel,
  output logic             adc_start,
  output logic [ADC_W-1:0] p1_value,
  output logic [ADC_W-1:0] p2_value,
  output logic             p1_valid,
  output logic             p2_valid,
  output logic             busy,
  output logic             timeout_err
);

  localparam int          ACC_W        = ADC_W + AVG_LOG2;
  localparam int          SAMPLES      = 1 << AVG_LOG2;
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST   = 32'(START_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  sched_state_t      state, state_nxt;
  logic [31:0]       cnt;
  logic [ACC_W-1:0]  acc;
  logic [AVG_LOG2:0] sample_cnt;
  logic [ADC_W-1:0]  avg;
  logic              channel;
  logic              rdy_s;
  logic              last_sample;
  logic              start_blocked;

  sync_2ff u_rdy_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .d       (adc_ready),
    .q       (rdy_s)
  );

  assign last_sample   = (int'(sample_cnt) == SAMPLES - 1);
  assign avg           = ADC_W'(acc >> AVG_LOG2);
  assign busy          = (state != IDLE);
  // A new pulse may not begin while the previous conversion's ready is still
  // seen high; once the pulse has begun (cnt > 0) it runs to full width.
  assign start_blocked = (state == START) && (cnt == '0) && rdy_s;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; adc_start is decoded from the state so that a reset
  // drops it in the same cycle.
  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = START;
      end
      START: begin
        if (!start_blocked) begin
          adc_start = 1'b1;
          if (cnt == PULSE_LAST) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rdy_s) state_nxt = CAPTURE;
        else if (cnt == TIMEOUT_LAST) state_nxt = TIMEOUT;
      end
      CAPTURE: begin
        state_nxt = last_sample ? PUBLISH : START;
      end
      PUBLISH, TIMEOUT: begin
        state_nxt = enable ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared cycle counter for SETTLE, START and WAIT; restarts on every state
  // change and is held at zero while a start pulse is being deferred.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state_nxt != state) || start_blocked) begin
      cnt <= '0;
    end else if (state inside {SETTLE, START, WAIT}) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Datapath: mux select, accumulation, publication and the error flag.
  // The average is registered on the CAPTURE->PUBLISH edge so the valid strobe
  // coincides with the PUBLISH cycle and the new value.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      adc_mux_sel <= CH_P1;
      channel     <= CH_P1;
      acc         <= '0;
      sample_cnt  <= '0;
      p1_value    <= '0;
      p2_value    <= '0;
      p1_valid    <= 1'b0;
      p2_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) adc_mux_sel <= channel;
        end
        WAIT: begin
          if (rdy_s) acc <= acc + ACC_W'(adc_data);
        end
        CAPTURE: begin
          sample_cnt <= sample_cnt + (AVG_LOG2 + 1)'(1);
          if (last_sample) begin
            if (channel == CH_P1) begin
              p1_value <= avg;
              p1_valid <= 1'b1;
            end else begin
              p2_value <= avg;
              p2_valid <= 1'b1;
            end
          end
        end
        PUBLISH, TIMEOUT: begin
          acc        <= '0;
          sample_cnt <= '0;
          channel    <= ~channel;
          if (enable) adc_mux_sel <= ~channel;
          if (state == TIMEOUT) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_adc_scheduler.sv
// Self-checking bench for paddle_adc_scheduler.
// An ADC model answers each start pulse; a reference model groups delivered
// samples per channel in scan order and queues the expected averages, which a
// monitor pops whenever the scheduler strobes a valid.
module tb_paddle_adc_scheduler;

  localparam int TB_AVG_LOG2 = 2;
  localparam int TB_SAMPLES  = 1 << TB_AVG_LOG2;

  typedef struct {
    int ch;
    int value;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] adc_data;
  logic       adc_ready;
  logic       adc_mux_sel;
  logic       adc_start;
  logic [7:0] p1_value;
  logic [7:0] p2_value;
  logic       p1_valid;
  logic       p2_valid;
  logic       busy;
  logic       timeout_err;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  int   grp[$];
  int   expChan = 0;
  int   expP1 = 0;
  int   expP2 = 0;
  logic expTimeout = 1'b0;
  logic prevErr = 1'b0;
  int   dataMode = 0;
  logic suppressCh1 = 1'b0;
  logic holdHigh = 1'b0;
  int   startCount = 0;
  logic lastStartMux = 1'b0;

  paddle_adc_scheduler #(
    .SETTLE_CYCLES      (4),
    .START_PULSE_CYCLES (2),
    .TIMEOUT_CYCLES     (20),
    .AVG_LOG2           (TB_AVG_LOG2)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .enable      (enable),
    .adc_data    (adc_data),
    .adc_ready   (adc_ready),
    .adc_mux_sel (adc_mux_sel),
    .adc_start   (adc_start),
    .p1_value    (p1_value),
    .p2_value    (p2_value),
    .p1_valid    (p1_valid),
    .p2_valid    (p2_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Record one comparison and report it if it does not hold.
  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive the enable input and choose how the ADC model produces results.
  task automatic applyStimulus(input logic en, input int mode);
    @(negedge sys_clk);
    enable   = en;
    dataMode = mode;
  endtask

  // Conversion result for a channel: 1 fixed per channel, 2 ramp on P1,
  // 3 full scale, otherwise random.
  function automatic logic [7:0] pickData(input int ch, input int idx);
    case (dataMode)
      1:       return (ch == 0) ? 8'h40 : 8'hC0;
      2:       return (ch == 0) ? 8'(10 + idx) : 8'($urandom);
      3:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic waitValid(input int ch, input int maxCyc);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!((ch == 0) ? p1_valid : p2_valid) && n < maxCyc);
    if (!((ch == 0) ? p1_valid : p2_valid)) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_valid ch=%0d actual=none required=strobe within %0d cycles", ch, maxCyc);
    end
  endtask

  // ADC and reference model. Ready rises 5 cycles after the start pulse
  // falls and is dropped 3 cycles later (or on the next start rising edge),
  // because the scheduler waits for ready to fall before the next pulse.
  initial begin : adcModel
    int   delay;
    int   hold;
    int   pulseLen;
    int   sinceMux;
    int   sum;
    logic startPrev;
    logic muxPrev;
    adc_ready = 1'b0;
    adc_data  = 8'h00;
    delay = 0; hold = 0; pulseLen = 0; sinceMux = 1000;
    startPrev = 1'b0; muxPrev = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (reset) begin
        adc_ready = 1'b0;
        delay = 0; hold = 0; pulseLen = 0; sinceMux = 1000;
        startPrev = 1'b0; muxPrev = 1'b0;
        expChan = 0; expP1 = 0; expP2 = 0; expTimeout = 1'b0;
        grp.delete();
        expQ.delete();
        continue;
      end
      if (adc_mux_sel != muxPrev) begin
        checkOutput("mux_change_start_low", int'(adc_start), 0);
        sinceMux = 0;
      end else if (sinceMux < 1000) begin
        sinceMux++;
      end
      muxPrev = adc_mux_sel;
      if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          adc_data  = pickData(expChan, grp.size());
          adc_ready = 1'b1;
          hold      = 3;
          grp.push_back(int'(adc_data));
          if (grp.size() == TB_SAMPLES) begin
            sum = 0;
            foreach (grp[i]) sum += grp[i];
            expQ.push_back('{ch: expChan, value: sum / TB_SAMPLES});
            if (expChan == 0) expP1 = sum / TB_SAMPLES;
            else expP2 = sum / TB_SAMPLES;
            grp.delete();
            expChan ^= 1;
          end
        end
      end else if (adc_ready && !holdHigh) begin
        hold--;
        if (hold <= 0) adc_ready = 1'b0;
      end
      if (adc_start && !startPrev) begin
        startCount++;
        lastStartMux = adc_mux_sel;
        checkOutput("start_channel", int'(adc_mux_sel), expChan);
        checkOutput("start_after_settle", int'(sinceMux >= 4), 1);
        checkOutput("start_ready_low", int'(adc_ready), 0);
        adc_ready = 1'b0;
        pulseLen  = 0;
      end
      if (adc_start) pulseLen++;
      if (!adc_start && startPrev) begin
        checkOutput("start_width", pulseLen, 2);
        if (suppressCh1 && expChan == 1) begin
          suppressCh1 = 1'b0;
          grp.delete();
          expChan ^= 1;
          expTimeout = 1'b1;
        end else begin
          delay = 5;
        end
      end
      startPrev = adc_start;
    end
  end

  // Scoreboard monitor: every valid strobe consumes one expected result.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!reset && (p1_valid || p2_valid)) begin
      checkOutput("valid_onehot", int'(p1_valid & p2_valid), 0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid actual=ch%0d required=no strobe", int'(p2_valid));
      end else begin
        e = expQ.pop_front();
        checkOutput("valid_channel", int'(p2_valid), e.ch);
        checkOutput("valid_value", p2_valid ? int'(p2_value) : int'(p1_value), e.value);
      end
    end
    if (!reset && timeout_err && !prevErr) begin
      checkOutput("timeout_expected", int'(expTimeout), 1);
    end
    prevErr = timeout_err;
  end

  initial begin : watchdog
    #300000;
    bad++;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int savedStarts;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_mux", int'(adc_mux_sel), 0);
    checkOutput("reset_start", int'(adc_start), 0);
    checkOutput("reset_p1", int'(p1_value), 0);
    checkOutput("reset_p2", int'(p2_value), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_err", int'(timeout_err), 0);
    reset = 1'b0;

    $display("[TB] fixed values per channel");
    applyStimulus(1'b1, 1);
    waitValid(0, 400);
    checkOutput("t1_p1_value", int'(p1_value), 8'h40);
    waitValid(1, 400);
    checkOutput("t1_p2_value", int'(p2_value), 8'hC0);

    $display("[TB] truncating average and full scale");
    dataMode = 2;
    waitValid(0, 400);
    checkOutput("t2_p1_ramp", int'(p1_value), 11);
    dataMode = 3;
    waitValid(0, 400);
    checkOutput("t2_p1_full", int'(p1_value), 255);

    $display("[TB] conversion timeout on player 2");
    suppressCh1 = 1'b1;
    n = 0;
    while (!timeout_err && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("t3_timeout_err", int'(timeout_err), 1);
    waitValid(0, 400);
    checkOutput("t3_p2_held", int'(p2_value), expP2);
    checkOutput("t3_err_sticky", int'(timeout_err), 1);

    $display("[TB] enable dropped mid-channel");
    dataMode = 0;
    n = 0;
    while (!(expChan == 0 && grp.size() == 1) && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("t4_second_conv_reached", int'(n < 400), 1);
    applyStimulus(1'b0, 0);
    waitValid(0, 400);
    repeat (5) @(negedge sys_clk);
    checkOutput("t4_idle_busy", int'(busy), 0);
    savedStarts = startCount;
    repeat (20) @(negedge sys_clk);
    checkOutput("t4_idle_no_start", startCount, savedStarts);
    applyStimulus(1'b1, 0);
    n = 0;
    while (startCount == savedStarts && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("t4_resume_channel", int'(lastStartMux), 1);

    $display("[TB] reset during a start pulse");
    n = 0;
    while (!(adc_start && grp.size() >= 1) && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    reset = 1'b1;
    @(negedge sys_clk);
    checkOutput("t5_start", int'(adc_start), 0);
    checkOutput("t5_mux", int'(adc_mux_sel), 0);
    checkOutput("t5_p1", int'(p1_value), 0);
    checkOutput("t5_p2", int'(p2_value), 0);
    checkOutput("t5_valids", int'({p1_valid, p2_valid}), 0);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_err", int'(timeout_err), 0);
    reset = 1'b0;
    waitValid(0, 400);
    waitValid(1, 400);

    $display("[TB] ready held high");
    holdHigh = 1'b1;
    n = 0;
    while (!adc_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    savedStarts = startCount;
    repeat (30) @(negedge sys_clk);
    checkOutput("t6_no_start", startCount, savedStarts);
    checkOutput("t6_start_low", int'(adc_start), 0);
    checkOutput("t6_busy", int'(busy), 1);
    holdHigh = 1'b0;
    n = 0;
    while (startCount == savedStarts && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("t6_resumed", int'(startCount > savedStarts), 1);

    $display("[TB] random data with enable gaps");
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (!(p1_valid || p2_valid) && n < 400);
      checkOutput("rand_publish_seen", int'(p1_valid || p2_valid), 1);
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(5, 30)) @(negedge sys_clk);
        enable = 1'b1;
      end
    end
    repeat (2) @(negedge sys_clk);
    checkOutput("final_p1_held", int'(p1_value), expP1);
    checkOutput("final_p2_held", int'(p2_value), expP2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
